fp8_drain: RTL and testbench
============================

# fp8_drain

Output-side packer for the FP8×FP8+FP16 systolic MAC. It accepts FP16 accumulator words, narrows them to FP8 (E4M3 or E5M2, chosen per word) or passes them through raw, and streams the result as bytes over a valid/ready handshake. It is the encode counterpart of the FP8 unpack stage at the MAC input. It sits between the accumulator result path and the 8-bit chip output port.

## Interface
No parameters; all widths are fixed by the FP8/FP16 formats.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  16  FP16 word (sign, 5-bit exponent, 10-bit mantissa)
- in_fmt  in  1  target format: 0 = E5M2, 1 = E4M3; sampled on accept
- in_raw  in  1  1 = emit the FP16 word as two bytes, high byte first; sampled on accept
- in_valid  in  1  in_data, in_fmt and in_raw are valid
- in_ready  out  1  the block accepts the word this cycle
- out_data  out  8  output byte, registered
- out_valid  out  1  out_data is valid, registered
- out_ready  in  1  downstream takes the byte this cycle
- ovf  out  1  sticky flag: some FP8 conversion saturated or overflowed to inf
- ovf_clr  in  1  synchronous clear of ovf; a set in the same cycle wins

## Operation
- A word is accepted when in_valid && in_ready.
- FSM states:
  - IDLE: out_valid = 0.
  - LAST: out_valid = 1; the byte shown is the final byte of its word.
  - HI: out_valid = 1; shows the high byte of a raw word, with the low byte held in lo_q.
- in_ready = (state == IDLE) || (state == LAST && out_ready). The block sustains one FP8 word per cycle. In HI, in_ready is 0.
- On accept from IDLE or LAST:
  - FP8 word: out_data ← converted byte, next state LAST.
  - Raw word: out_data ← in_data[15:8], lo_q ← in_data[7:0], next state HI.
- HI && out_ready: out_data ← lo_q, next state LAST.
- LAST && out_ready with no accept: next state IDLE.
- Whenever out_valid && !out_ready, out_data is held stable.
- Conversion is fp16_to_fp8, rounding to nearest, ties to even:
  - FP16 NaN → 0x7F in both formats.
  - E5M2: same bias of 15. Round the 10-bit mantissa to 2 bits; a mantissa carry increments the exponent. A result exponent of 31 gives ±inf (S,11111,00) and sets ovf. FP16 inf gives ±inf and does not set ovf. FP16 subnormals and values below 2^-14 become E5M2 subnormals m·2^-16, rounded, and may flush to ±0.
  - E4M3: bias 7, no inf, max finite ±448 (0x7E/0xFE). A finite value that rounds above 448 saturates to ±448 and sets ovf. FP16 ±inf → ±448 and sets ovf. Values below 2^-6 become subnormals m·2^-9, rounded, and may flush to ±0.
  - Zero keeps its sign.

## Timing
- Reset values: state = IDLE, out_valid = 0, out_data = 0x00, lo_q = 0x00, ovf = 0, in_ready = 1 (combinational from state).
- Latency: a word accepted at edge t has its first byte valid after edge t; a raw word's low byte follows no earlier than edge t+1.
- Simultaneous events:
  - Accept and out_ready in LAST is a back-to-back handoff with no bubble.
  - ovf_clr together with a new overflow leaves ovf = 1.
- Reset asserted mid-word (HI or LAST) clears the FSM immediately and without waiting for a clock edge; the pending byte is dropped.
- in_fmt and in_raw are don't-care when not accepted.

## Structure
- Shared package fp_pkg holds:
  - FP16 and FP8 field widths and biases (15, 7).
  - Format codes FMT_E5M2 = 0, FMT_E4M3 = 1.
  - Constants FP8_NAN = 0x7F, E4M3_MAX = 0x7E, E5M2_INF = 0x7C.
  - The state enum {IDLE, HI, LAST}.
- Combinational sub-module fp16_to_fp8 (in: 16-bit word, fmt; out: 8-bit byte, ovf). fp8_drain holds only the FSM and the registers.

## Test plan
- Format and rounding, out_ready held 1:
  - 0x3C00 → E5M2 0x3C and E4M3 0x38.
  - 0x3C80 (1.125, tie) → E5M2 0x3C.
  - 0x3D80 (1.375, tie) → E5M2 0x3E.
- Overflow:
  - 0x7BFF → E5M2 0x7C with ovf = 1.
  - After ovf_clr, 0xFBFF → E4M3 0xFE with ovf = 1.
- Specials:
  - 0x7E00 → 0x7F in both formats.
  - 0x1800 → E4M3 0x01.
  - 0x8000 → 0x80.
- Raw backpressure:
  - Raw 0x1234 with out_ready low for 3 cycles: out_data holds 0x12 and in_ready stays 0.
  - Then out_ready goes high: 0x34 appears, followed by IDLE.
- Throughput: 8 FP8 words with in_valid and out_ready held at 1 produce 8 bytes on 8 consecutive cycles, with no bubble.
- Reset: assert rst while in HI with out_ready = 0. out_valid falls to 0 without waiting for a clock edge, ovf = 0, and the next accepted word starts cleanly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP16/FP8 format constants and the drain state encoding.
package fp_pkg;

  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;
  localparam int unsigned E5M2_MAN_W = 2;
  localparam int unsigned E4M3_MAN_W = 3;

  localparam int unsigned FP16_BIAS = 15;
  localparam int unsigned E5M2_BIAS = 15;
  localparam int unsigned E4M3_BIAS = 7;

  localparam logic FMT_E5M2 = 1'b0;
  localparam logic FMT_E4M3 = 1'b1;

  localparam logic [7:0] FP8_NAN  = 8'h7F;
  localparam logic [7:0] E4M3_MAX = 8'h7E;
  localparam logic [7:0] E5M2_INF = 8'h7C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LAST = 2'd2
  } drain_state_t;

endpackage

// File: rtl/fp8_drain_if.sv
// Word-in / byte-out handshake bundle of the FP8 drain.
interface fp8_drain_if;
  logic [15:0] in_data;
  logic        in_fmt;
  logic        in_raw;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_fmt, in_raw, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_fmt, in_raw, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fp16_to_fp8.sv
// Combinational FP16 -> FP8 (E5M2 / E4M3) narrowing, round to nearest even.
module fp16_to_fp8
  import fp_pkg::*;
(
  input  logic [15:0] fp16,
  input  logic        fmt,
  output logic [7:0]  fp8,
  output logic        ovf
);

  localparam logic signed [6:0] SRC_BIAS  = 7'(FP16_BIAS);
  localparam logic signed [6:0] BIAS_E5M2 = 7'(E5M2_BIAS);
  localparam logic signed [6:0] BIAS_E4M3 = 7'(E4M3_BIAS);
  localparam logic [4:0]        SH_E5M2   = 5'(FP16_MAN_W - E5M2_MAN_W);
  localparam logic [4:0]        SH_E4M3   = 5'(FP16_MAN_W - E4M3_MAN_W);

  logic                  sgn;
  logic [FP16_EXP_W-1:0] exp;
  logic [FP16_MAN_W-1:0] man;

  assign sgn = fp16[15];
  assign exp = fp16[FP16_MAN_W +: FP16_EXP_W];
  assign man = fp16[FP16_MAN_W-1:0];

  logic               hidden;
  logic [4:0]         exp_eff;
  logic signed [6:0]  te;
  logic [3:0]         under;
  logic [4:0]         shift;
  logic [22:0]        ext;
  logic [10:0]        q;
  logic               rnd_up;
  logic [6:0]         base;
  logic [11:0]        code;

  // Code = (target exponent - 1) << M plus the rounded significand with its
  // hidden bit, so mantissa carries and subnormal->normal rollover fall out.
  always_comb begin
    hidden  = (exp != 5'd0);
    exp_eff = hidden ? exp : 5'd1;
    te      = $signed({2'b00, exp_eff}) - SRC_BIAS
              + ((fmt == FMT_E4M3) ? BIAS_E4M3 : BIAS_E5M2);
    under   = (te < 7'sd1) ? 4'(7'sd1 - te) : 4'd0;
    shift   = ((fmt == FMT_E4M3) ? SH_E4M3 : SH_E5M2) + {1'b0, under};
    ext     = {hidden, man, 12'b0} >> shift;
    q       = ext[22:12];
    rnd_up  = ext[11] & ((|ext[10:0]) | q[0]);
    base    = (hidden && (te >= 7'sd1)) ? 7'(te - 7'sd1) : 7'd0;
    code    = ((fmt == FMT_E4M3) ? ({5'd0, base} << E4M3_MAN_W)
                                 : ({5'd0, base} << E5M2_MAN_W))
              + {1'b0, q} + {11'd0, rnd_up};

    fp8 = {sgn, code[6:0]};
    ovf = 1'b0;
    if (exp == 5'h1F) begin
      if (man != 10'd0) begin
        fp8 = FP8_NAN;
      end else if (fmt == FMT_E4M3) begin
        fp8 = {sgn, 7'd0} | E4M3_MAX;
        ovf = 1'b1;
      end else begin
        fp8 = {sgn, 7'd0} | E5M2_INF;
      end
    end else if (fmt == FMT_E4M3) begin
      if (code > {4'd0, E4M3_MAX}) begin
        fp8 = {sgn, 7'd0} | E4M3_MAX;
        ovf = 1'b1;
      end
    end else if (code >= {4'd0, E5M2_INF}) begin
      fp8 = {sgn, 7'd0} | E5M2_INF;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/fp8_drain.sv
// Byte-stream packer: FP16 accumulator words out as FP8 bytes or raw pairs.
//   IDLE | no byte on the output
//   HI   | high byte of a raw word shown, low byte parked in lo_q
//   LAST | final byte of the current word shown
module fp8_drain
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  fp8_drain_if.slave  bus,
  output logic        ovf,
  input  logic        ovf_clr
);

  drain_state_t state;
  logic [7:0]   lo_q;
  logic [7:0]   cvt_byte;
  logic         cvt_ovf;
  logic         accept;

  fp16_to_fp8 u_cvt (
    .fp16 (bus.in_data),
    .fmt  (bus.in_fmt),
    .fp8  (cvt_byte),
    .ovf  (cvt_ovf)
  );

  assign bus.in_ready = (state == IDLE) || ((state == LAST) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'h00;
      lo_q          <= 8'h00;
      ovf           <= 1'b0;
    end else begin
      // A new overflow outranks a clear in the same cycle.
      if (accept && !bus.in_raw && cvt_ovf) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end

      case (state)
        IDLE, LAST: begin
          if (accept) begin
            bus.out_valid <= 1'b1;
            if (bus.in_raw) begin
              bus.out_data <= bus.in_data[15:8];
              lo_q         <= bus.in_data[7:0];
              state        <= HI;
            end else begin
              bus.out_data <= cvt_byte;
              state        <= LAST;
            end
          end else if ((state == LAST) && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        HI: begin
          if (bus.out_ready) begin
            bus.out_data <= lo_q;
            state        <= LAST;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_drain.sv
// Directed bench for fp8_drain: conversion, overflow flag, raw backpressure, throughput, reset.
module tb_fp8_drain;

  logic clk;
  logic rst;
  logic ovf;
  logic ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  fp8_drain_if bus ();

  fp8_drain u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h want 0x%h", tag, got, exp);
    end
  endtask

  // One FP8 word through with out_ready high; byte checked one edge later.
  task automatic put_fp8(input logic [15:0] d, input logic f, input logic [7:0] exp,
                         input string tag);
    bus.in_data  = d;
    bus.in_fmt   = f;
    bus.in_raw   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk(tag, {8'h00, bus.out_data}, {8'h00, exp});
    chk({tag, "_v"}, {15'd0, bus.out_valid}, 16'd1);
  endtask

  logic [15:0] tp_data [8] = '{16'h3C00, 16'h3C00, 16'h4000, 16'h4000,
                               16'hC000, 16'h3E00, 16'h0100, 16'h2380};
  logic        tp_fmt  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0]  tp_exp  [8] = '{8'h3C, 8'h38, 8'h40, 8'h40,
                               8'hC0, 8'h3C, 8'h01, 8'h08};

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    ovf_clr       = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_fmt    = 1'b0;
    bus.in_raw    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_data",  {8'h00, bus.out_data},  16'h0000);
    chk("rst_ready", {15'd0, bus.in_ready},  16'd1);
    chk("rst_ovf",   {15'd0, ovf},           16'd0);

    // Format and rounding
    bus.out_ready = 1'b1;
    put_fp8(16'h3C00, 1'b0, 8'h3C, "one_e5m2");
    put_fp8(16'h3C00, 1'b1, 8'h38, "one_e4m3");
    put_fp8(16'h3C80, 1'b0, 8'h3C, "tie_down");
    put_fp8(16'h3D80, 1'b0, 8'h3E, "tie_up");
    put_fp8(16'h2380, 1'b1, 8'h08, "sub_carry");
    put_fp8(16'h0100, 1'b0, 8'h01, "e5m2_sub");
    put_fp8(16'h0001, 1'b0, 8'h00, "e5m2_flush");
    put_fp8(16'h5F40, 1'b1, 8'h7E, "e4m3_464");
    chk("ovf_quiet", {15'd0, ovf}, 16'd0);

    // Overflow
    put_fp8(16'h7BFF, 1'b0, 8'h7C, "e5m2_ovf");
    chk("ovf_set", {15'd0, ovf}, 16'd1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    chk("ovf_clr", {15'd0, ovf}, 16'd0);
    ovf_clr = 1'b1;
    put_fp8(16'hFBFF, 1'b1, 8'hFE, "e4m3_sat");
    ovf_clr = 1'b0;
    chk("ovf_set_wins", {15'd0, ovf}, 16'd1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    put_fp8(16'h5F80, 1'b1, 8'h7E, "e4m3_480");
    chk("ovf_480", {15'd0, ovf}, 16'd1);

    // Specials
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    put_fp8(16'h7E00, 1'b0, 8'h7F, "nan_e5m2");
    put_fp8(16'h7E00, 1'b1, 8'h7F, "nan_e4m3");
    put_fp8(16'h7C00, 1'b0, 8'h7C, "inf_e5m2");
    chk("ovf_nan_inf", {15'd0, ovf}, 16'd0);
    put_fp8(16'h1800, 1'b1, 8'h01, "e4m3_min");
    put_fp8(16'h8000, 1'b0, 8'h80, "negzero");
    put_fp8(16'h8000, 1'b1, 8'h80, "negzero4");
    put_fp8(16'hFC00, 1'b1, 8'hFE, "ninf_e4m3");
    chk("ovf_inf4", {15'd0, ovf}, 16'd1);

    // Raw word under backpressure
    @(posedge clk);
    #1;
    bus.in_data   = 16'h1234;
    bus.in_raw    = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("raw_hi",    {8'h00, bus.out_data},  16'h0012);
    chk("raw_hi_v",  {15'd0, bus.out_valid}, 16'd1);
    chk("raw_hi_rdy",{15'd0, bus.in_ready},  16'd0);
    bus.in_data = 16'h3C00;
    bus.in_raw  = 1'b0;
    bus.in_fmt  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("raw_hold%0d", i), {8'h00, bus.out_data}, 16'h0012);
      chk($sformatf("raw_rdy%0d", i),  {15'd0, bus.in_ready}, 16'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("hi_rdy_or", {15'd0, bus.in_ready}, 16'd0);
    @(posedge clk);
    #1;
    chk("raw_lo",     {8'h00, bus.out_data},  16'h0034);
    chk("raw_lo_v",   {15'd0, bus.out_valid}, 16'd1);
    chk("raw_lo_rdy", {15'd0, bus.in_ready},  16'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("handoff", {8'h00, bus.out_data}, 16'h003C);
    @(posedge clk);
    #1;
    chk("idle_v", {15'd0, bus.out_valid}, 16'd0);

    // Throughput: one byte per cycle
    bus.in_raw   = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = tp_data[i];
      bus.in_fmt  = tp_fmt[i];
      @(posedge clk);
      #1;
      chk($sformatf("tput%0d", i),   {8'h00, bus.out_data},  {8'h00, tp_exp[i]});
      chk($sformatf("tput_v%0d", i), {15'd0, bus.out_valid}, 16'd1);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("tput_end", {15'd0, bus.out_valid}, 16'd0);

    // Asynchronous reset mid-word
    put_fp8(16'h7BFF, 1'b0, 8'h7C, "pre_rst");
    bus.in_data  = 16'hABCD;
    bus.in_raw   = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("rst_hi", {8'h00, bus.out_data}, 16'h00AB);
    rst = 1'b1;
    #1;
    chk("arst_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("arst_ovf",   {15'd0, ovf},           16'd0);
    chk("arst_data",  {8'h00, bus.out_data},  16'h0000);
    chk("arst_ready", {15'd0, bus.in_ready},  16'd1);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_v", {15'd0, bus.out_valid}, 16'd0);
    bus.out_ready = 1'b1;
    put_fp8(16'h3C00, 1'b1, 8'h38, "post_rst");
    chk("post_rst_ovf", {15'd0, ovf}, 16'd0);
    @(posedge clk);
    #1;
    chk("final_idle", {15'd0, bus.out_valid}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
